// File: rtl/audio_codec_serializer.sv
// -----------------------------------------------------------------------------
// audio_codec_serializer
//   Serial audio bridge to a WM8731-style codec running in left-justified
//   master-clocked mode. An 8-bit frame counter (256 audio_clk cycles = one
//   44.1 kHz frame) derives BCLK (clk/4) and the LR frame clock. One mono
//   sample is shifted out MSB-first on both DAC channels. The left ADC channel
//   is captured and presented once per frame.
//
// Optional feature: define CODEC_MUTE_EN to add a 'mute' input. When mute is
//   high at the sample-latch edge, a zero sample is latched instead.
//
// Ports
//   audio_clk     in   codec master clock, all logic on rising edge
//   reset         in   synchronous active-high reset
//   mute          in   (CODEC_MUTE_EN only) force latched sample to 0
//   audio_output  in   16-bit signed sample from effects stage (taken at fcnt 254)
//   AUD_ADCDAT    in   serial ADC data from codec
//   sample_req    out  1-cycle pulse at fcnt 253: producer should present sample
//   sample_end    out  1-cycle pulse at fcnt 65: audio_input has a new value
//   audio_input   out  last captured left-channel ADC sample
//   AUD_BCLK      out  bit clock (fcnt[1])
//   AUD_DACLRCK   out  DAC frame clock (fcnt[7]; 0 = left)
//   AUD_ADCLRCK   out  ADC frame clock (same as AUD_DACLRCK)
//   AUD_DACDAT    out  serial DAC data, MSB first
// -----------------------------------------------------------------------------
module audio_codec_serializer (
  input  logic        audio_clk,
  input  logic        reset,
`ifdef CODEC_MUTE_EN
  input  logic        mute,
`endif
  input  logic [15:0] audio_output,
  input  logic        AUD_ADCDAT,
  output logic        sample_req,
  output logic        sample_end,
  output logic [15:0] audio_input,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_ADCLRCK,
  output logic        AUD_DACDAT
);

  logic [7:0]  fcnt, fcnt_nxt;
  logic [15:0] hold_q, hold_nxt;
  logic [15:0] dac_sr, dac_nxt;
  logic [15:0] adc_sr, adc_nxt;
  logic        dac_load, dac_shift, adc_shift;

  always_comb begin
    fcnt_nxt = fcnt + 8'd1;

    // Sample is latched one full cycle after sample_req so the producer has
    // a whole cycle to respond; changes at any other time are ignored.
    hold_nxt = hold_q;
    if (fcnt == 8'd254) begin
`ifdef CODEC_MUTE_EN
      hold_nxt = mute ? 16'h0000 : audio_output;
`else
      hold_nxt = audio_output;
`endif
    end

    // Reload at the end of each half-frame (127 and 255), so both channels
    // carry the same sample. Otherwise shift on every BCLK falling edge;
    // after 16 shifts the register is all zeros, giving silent padding.
    dac_load  = (fcnt[6:0] == 7'h7F);
    dac_shift = (fcnt[1:0] == 2'd3) && !dac_load;
    dac_nxt   = dac_sr;
    if (dac_load)
      dac_nxt = hold_q;
    else if (dac_shift)
      dac_nxt = {dac_sr[14:0], 1'b0};

    // Capture ADC data in the middle of BCLK high, left-channel data bits only.
    adc_shift = (fcnt[1:0] == 2'd2) && (fcnt[7:6] == 2'b00);
    adc_nxt   = adc_shift ? {adc_sr[14:0], AUD_ADCDAT} : adc_sr;
  end

  // Codec-facing outputs are registered from next-state values so they line
  // up exactly with fcnt while having no combinational path to the pins.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      fcnt        <= 8'd0;
      hold_q      <= 16'h0000;
      dac_sr      <= 16'h0000;
      adc_sr      <= 16'h0000;
      audio_input <= 16'h0000;
      sample_req  <= 1'b0;
      sample_end  <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_ADCLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else begin
      fcnt        <= fcnt_nxt;
      hold_q      <= hold_nxt;
      dac_sr      <= dac_nxt;
      adc_sr      <= adc_nxt;
      if (fcnt == 8'd64)
        audio_input <= adc_sr;
      sample_end  <= (fcnt == 8'd64);
      sample_req  <= (fcnt_nxt == 8'd253);
      AUD_BCLK    <= fcnt_nxt[1];
      AUD_DACLRCK <= fcnt_nxt[7];
      AUD_ADCLRCK <= fcnt_nxt[7];
      AUD_DACDAT  <= dac_nxt[15];
    end
  end

endmodule

// File: tb/tb_audio_codec_serializer.sv
// -----------------------------------------------------------------------------
// tb_audio_codec_serializer
//   Frame-level vectors (sample to transmit, ADC word to feed, expected
//   results) are applied one per 256-cycle frame. Expected DAC words and ADC
//   words are pushed to scoreboard queues when the stimulus is driven and
//   popped when the DUT should produce them. Every cycle the clocks, pulses
//   and the serial DAC bit are compared against an independent frame model.
//   Hand-written sequences cover reset, sample_req timing after release and a
//   mid-frame reset.
// -----------------------------------------------------------------------------
module tb_audio_codec_serializer;

  logic        audio_clk = 1'b0;
  logic        reset;
  logic [15:0] audio_output;
  logic        AUD_ADCDAT;
  logic        sample_req, sample_end;
  logic [15:0] audio_input;
  logic        AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT;
`ifdef CODEC_MUTE_EN
  logic        mute;
`endif

  audio_codec_serializer dut (
    .audio_clk    (audio_clk),
    .reset        (reset),
`ifdef CODEC_MUTE_EN
    .mute         (mute),
`endif
    .audio_output (audio_output),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .sample_req   (sample_req),
    .sample_end   (sample_end),
    .audio_input  (audio_input),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_DACDAT   (AUD_DACDAT)
  );

  always #5 audio_clk = ~audio_clk;

  typedef struct {
    logic [15:0] audio;    // sample presented at fcnt 254
    logic [15:0] adc;      // word fed on AUD_ADCDAT in left half
    logic        mute;
    logic [15:0] exp_dac;  // word expected on AUD_DACDAT next frame
    logic [15:0] exp_adc;  // expected audio_input at fcnt 65
  } vec_t;

  vec_t        vecs[6];
  vec_t        rec;
  logic [15:0] dac_q[$];
  logic [15:0] adc_q[$];
  logic [15:0] cur_word;
  int          mf;
  int          rel_cyc;
  int          req_cyc[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (model fcnt %0d, t=%0t)", name, act, exp, mf, $time);
    end
  endtask

  // Drive inputs for the current cycle, take one edge, update the model and
  // compare outputs 1 time unit after the edge.
  task automatic tick();
    logic rst_edge;
    logic dexp;
    audio_output = (mf == 254) ? rec.audio : 16'($urandom);
    AUD_ADCDAT   = (mf < 64) ? rec.adc[15 - (mf / 4)] : 1'($urandom);
`ifdef CODEC_MUTE_EN
    mute = rec.mute;
`endif
    rst_edge = reset;
    @(posedge audio_clk);
    #1;
    if (rst_edge) begin
      mf = 0;
      cur_word = 16'h0000;
      dac_q.delete();
      adc_q.delete();
    end else begin
      if (mf == 254) dac_q.push_back(rec.exp_dac);
      if (mf == 63)  adc_q.push_back(rec.exp_adc);
      mf = (mf + 1) % 256;
      rel_cyc++;
      if (mf == 0) begin
        if (dac_q.size() > 0) cur_word = dac_q.pop_front();
        else cur_word = 16'h0000;
      end
    end

    if (rst_edge) chk("reset_audio_input", audio_input, 16'h0000);
    chk("bclk", AUD_BCLK, mf[1]);
    chk("daclrck", AUD_DACLRCK, mf[7]);
    chk("adclrck", AUD_ADCLRCK, mf[7]);
    chk("sample_req", sample_req, (mf == 253));
    chk("sample_end", sample_end, (mf == 65));
    dexp = (mf[6] == 1'b0) ? cur_word[15 - ((mf % 64) / 4)] : 1'b0;
    chk("dacdat", AUD_DACDAT, dexp);
    if (mf == 65) begin
      if (adc_q.size() > 0) chk("audio_input", audio_input, adc_q.pop_front());
      else chk("adc_scoreboard_nonempty", 0, 1);
    end
    if (sample_req && !rst_edge && req_cyc.size() < 3) req_cyc.push_back(rel_cyc);
  endtask

  task automatic run_frame(input vec_t v);
    rec = v;
    for (int i = 0; i < 256; i++) tick();
  endtask

  initial begin
    vecs[0] = '{audio: 16'hA5C3, adc: 16'h8001, mute: 1'b0, exp_dac: 16'hA5C3, exp_adc: 16'h8001};
    vecs[1] = '{audio: 16'h0000, adc: 16'hFFFF, mute: 1'b0, exp_dac: 16'h0000, exp_adc: 16'hFFFF};
    vecs[2] = '{audio: 16'h8000, adc: 16'h1234, mute: 1'b0, exp_dac: 16'h8000, exp_adc: 16'h1234};
`ifdef CODEC_MUTE_EN
    vecs[3] = '{audio: 16'h7FFF, adc: 16'h0000, mute: 1'b1, exp_dac: 16'h0000, exp_adc: 16'h0000};
`else
    vecs[3] = '{audio: 16'h7FFF, adc: 16'h0000, mute: 1'b0, exp_dac: 16'h7FFF, exp_adc: 16'h0000};
`endif
    vecs[4] = '{audio: 16'h7FFF, adc: 16'h5A5A, mute: 1'b0, exp_dac: 16'h7FFF, exp_adc: 16'h5A5A};
    vecs[5] = '{audio: 16'hFFFF, adc: 16'hC003, mute: 1'b0, exp_dac: 16'hFFFF, exp_adc: 16'hC003};

    // Reset for a few cycles: every edge under reset must give all-zero outputs.
    mf = 0;
    rel_cyc = 0;
    cur_word = 16'h0000;
    rec = vecs[0];
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    rel_cyc = 0;  // this cycle is fcnt 0 after release

    foreach (vecs[i]) run_frame(vecs[i]);

    // sample_req pulses at 253, 509, 765 cycles after release.
    if (req_cyc.size() == 3) begin
      chk("req_cycle_0", req_cyc[0], 253);
      chk("req_cycle_1", req_cyc[1], 509);
      chk("req_cycle_2", req_cyc[2], 765);
    end else begin
      chk("req_pulse_count", req_cyc.size(), 3);
    end

    // Mid-frame reset at fcnt 100: frame aborted, next frame must be silent,
    // the one after carries the first post-reset sample.
    rec = vecs[5];
    while (mf != 100) tick();
    reset = 1'b1;
    tick();
    chk("mid_reset_dacdat", AUD_DACDAT, 1'b0);
    chk("mid_reset_sample_req", sample_req, 1'b0);
    reset = 1'b0;
    run_frame(vecs[0]);   // silent frame (cur_word cleared by reset)
    run_frame(vecs[2]);   // transmits vecs[0] sample
    run_frame(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
